dm_access_ctrl: RTL and testbench
=================================

Name: dm_access_ctrl

Overview:
- Sequences every M-stage data-memory access over a req/ack bus to a variable-latency data memory, and stalls the pipeline until the access completes.
- Decodes the load/store opcode, checks alignment, forms the word address, byte enables and replicated store data, and runs the bus handshake with a timeout.
- Returns the raw 32-bit read word to the downstream load-extension stage, which selects and extends the byte or half.

Parameters:
TIMEOUT, 16, maximum BUSY cycles waited for mem_ack before aborting with bus_err (must be at least 2).
CNT_W, $clog2(TIMEOUT), width of the timeout counter.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
Instr_M  input  32  M-stage instruction; opcode is bits 31:26.
ALUout  input  32  effective byte address.
WD_M  input  32  store data (rt value).
mem_req  output  1  bus request; registered.
mem_we  output  1  1 = store, 0 = load; registered.
mem_addr  output  32  word address, {ALUout[31:2],2'b00}; registered.
mem_be  output  4  byte enables; registered.
mem_wdata  output  32  replicated store data; registered.
mem_ack  input  1  memory completion, 1-cycle pulse.
mem_rdata  input  32  read word, valid when mem_ack=1.
DMout1  output  32  captured read word for the load-extension stage.
stall  output  1  freezes F/D/E/M; combinational.
adel  output  1  load address-error exception; combinational.
ades  output  1  store address-error exception; combinational.
bus_err  output  1  one-cycle pulse when an access times out.

Behaviour:
- Opcodes:
  - Loads: lb 100000, lbu 100100, lh 100001, lhu 100101, lw 100011.
  - Stores: sb 101000, sh 101001, sw 101011.
  - Any other opcode is not a memory op.
- Alignment:
  - Half accesses require ALUout[0]=0.
  - Word accesses require ALUout[1:0]=00.
  - A misaligned load raises adel and a misaligned store raises ades, only in IDLE. No request is issued and stall=0.
- Byte enables:
  - sb: 4'b0001 << ALUout[1:0].
  - sh: ALUout[1] ? 4'b1100 : 4'b0011.
  - sw and all loads: 4'b1111.
- Store data:
  - sb: {4{WD_M[7:0]}}.
  - sh: {2{WD_M[15:0]}}.
  - sw: WD_M.
  - loads: 0.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - On an aligned memory op, register mem_req=1 and mem_we/mem_addr/mem_be/mem_wdata, clear the counter, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Bus outputs are held stable.
  - If mem_ack=1: capture mem_rdata into DOUT (loads only; DMout1 keeps its value on stores), clear mem_req, go to DONE.
  - Else if counter == TIMEOUT-1: clear mem_req, pulse bus_err, set DMout1 to 0 on loads, go to DONE.
  - Else increment the counter.
- DONE: stall=0 for exactly one cycle so the pipeline advances past the instruction; go to IDLE unconditionally, with no re-issue.
- stall = (IDLE && aligned memory op) || BUSY.
- Latency: with ack on the k-th BUSY cycle, the instruction leaves M after k+2 cycles. The minimum is 3 (issue, ack, DONE).
- mem_ack outside BUSY is ignored. The ack may arrive in the first BUSY cycle.
- Reset (synchronous, any state including mid-BUSY):
  - State returns to IDLE.
  - mem_req, mem_we, mem_addr, mem_be, mem_wdata, DMout1, bus_err and the counter are all cleared.
  - The outstanding transaction is abandoned, and a late ack after reset is ignored.
- Back-to-back memory ops: the next op is issued from IDLE on the cycle after DONE.

Decomposition:
- Shared package:
  - opcode constants (lb, lbu, lh, lhu, lw, sb, sh, sw);
  - the access-size encoding (BYTE, HALF, WORD);
  - FSM state encoding.
- One combinational sub-module, dm_be_gen: opcode + ALUout[1:0] + WD_M in, giving is_load, is_store, misaligned, mem_be and mem_wdata out.
- The FSM, counter and capture register live in the top module.

Test Plan:
- lw, ALUout=0x104, ack on the 1st BUSY cycle, rdata=0xDEADBEEF → mem_addr=0x104, mem_be=1111, mem_we=0; stall high 2 cycles; DMout1=0xDEADBEEF in DONE.
- sb, ALUout=0x203, WD_M=0x12345678, ack after 3 cycles → mem_be=1000, mem_wdata=0x78787878, mem_we=1; stall high 4 cycles.
- sh at 0x202 → mem_be=1100, wdata=0x56785678. lh at 0x201 → adel=1, mem_req stays 0, stall=0. sw at 0x102 → ades=1.
- lw, ack never arrives, TIMEOUT=16 → mem_req high 16 cycles; bus_err pulses once; DMout1=0; DONE then IDLE.
- reset asserted on the 2nd BUSY cycle, then ack the next cycle → all outputs 0, state IDLE, ack ignored, no stall.
- Back-to-back lw then sw, each with 1-cycle ack → second mem_req rises exactly one cycle after the first DONE; non-memory opcode (addu) → no req, stall=0.

Source files
------------

// File: rtl/dm_access_ctrl_pkg.sv
// Shared definitions for the M-stage data-memory access controller:
// load/store opcodes, access-size and FSM state encodings.
package dm_access_ctrl_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {BYTE, HALF, WORD} acc_size_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} dm_state_t;

    // Non-memory opcodes fall through to WORD; callers gate on is_load/is_store.
    function automatic acc_size_t op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return BYTE;
            OP_LH, OP_LHU, OP_SH: return HALF;
            default:              return WORD;
        endcase
    endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Request/acknowledge bus between the access controller and the data memory.
interface dm_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dm_access_ctrl_be_gen.sv
// Opcode decode, alignment check, byte-enable and replicated store-data generation.
module dm_be_gen
    import dm_access_ctrl_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wd,
    output logic        is_load,
    output logic        is_store,
    output logic        misaligned,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata
);
    acc_size_t size;
    logic      bad_align;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        case (opcode)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load  = 1'b1;
            OP_SB, OP_SH, OP_SW:                 is_store = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        size      = op_size(opcode);
        bad_align = 1'b0;
        mem_be    = 4'b1111;
        mem_wdata = '0;
        case (size)
            BYTE: begin
                if (is_store) begin
                    mem_be    = 4'b0001 << addr_lo;
                    mem_wdata = {4{wd[7:0]}};
                end
            end
            HALF: begin
                bad_align = addr_lo[0];
                if (is_store) begin
                    mem_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{wd[15:0]}};
                end
            end
            default: begin
                bad_align = |addr_lo;
                if (is_store) mem_wdata = wd;
            end
        endcase
        misaligned = bad_align && (is_load || is_store);
    end
endmodule

// File: rtl/dm_access_ctrl.sv
// M-stage data-memory access sequencer: issues one bus request per aligned
// load/store, stalls the pipeline until ack or timeout, captures the read word.
module dm_access_ctrl
    import dm_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              Instr_M,
    input  logic [31:0]              ALUout,
    input  logic [31:0]              WD_M,
    dm_access_ctrl_if.master         bus,
    output logic [31:0]              DMout1,
    output logic                     stall,
    output logic                     adel,
    output logic                     ades,
    output logic                     bus_err
);
    dm_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             is_load, is_store, misaligned;
    logic [3:0]       be_nxt;
    logic [31:0]      wdata_nxt;
    logic             issue, timed_out;
    logic             unused_instr_bits;

    assign unused_instr_bits = ^Instr_M[25:0];

    dm_be_gen u_be_gen (
        .opcode     (Instr_M[31:26]),
        .addr_lo    (ALUout[1:0]),
        .wd         (WD_M),
        .is_load    (is_load),
        .is_store   (is_store),
        .misaligned (misaligned),
        .mem_be     (be_nxt),
        .mem_wdata  (wdata_nxt)
    );

    assign issue     = (state == IDLE) && (is_load || is_store) && !misaligned;
    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = BUSY;
            BUSY:    if (bus.mem_ack || timed_out) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall = issue || (state == BUSY);
        adel  = (state == IDLE) && is_load  && misaligned;
        ades  = (state == IDLE) && is_store && misaligned;
    end

    // Bus outputs are only written on issue, so they stay stable through BUSY.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
            DMout1        <= '0;
            bus_err       <= 1'b0;
            cnt           <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= is_store;
                        bus.mem_addr  <= {ALUout[31:2], 2'b00};
                        bus.mem_be    <= be_nxt;
                        bus.mem_wdata <= wdata_nxt;
                        cnt           <= '0;
                    end
                end
                BUSY: begin
                    if (bus.mem_ack) begin
                        if (!bus.mem_we) DMout1 <= bus.mem_rdata;
                        bus.mem_req <= 1'b0;
                    end else if (timed_out) begin
                        if (!bus.mem_we) DMout1 <= '0;
                        bus.mem_req <= 1'b0;
                        bus_err     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed scenarios followed by
// randomized transactions against a transaction-level reference model.
module tb_dm_access_ctrl;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr_M, ALUout, WD_M;
    logic [31:0] DMout1;
    logic        stall, adel, ades, bus_err;

    dm_access_ctrl_if bus ();

    dm_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset   (reset),
        .Instr_M (Instr_M),
        .ALUout  (ALUout),
        .WD_M    (WD_M),
        .bus     (bus),
        .DMout1  (DMout1),
        .stall   (stall),
        .adel    (adel),
        .ades    (ades),
        .bus_err (bus_err)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] exp_dout;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference model: opcode -> access size in bytes (0 = not a memory op).
    function automatic int size_of(input logic [5:0] op);
        case (op)
            6'b100000, 6'b100100, 6'b101000: return 1;
            6'b100001, 6'b100101, 6'b101001: return 2;
            6'b100011, 6'b101011:            return 4;
            default:                         return 0;
        endcase
    endfunction

    function automatic bit is_st(input logic [5:0] op);
        return op == 6'b101000 || op == 6'b101001 || op == 6'b101011;
    endfunction

    function automatic logic [3:0] model_be(input int sz, input bit st, input logic [31:0] a);
        if (!st || sz == 4) return 4'hF;
        if (sz == 1) return 4'(1 << (a % 4));
        return ((a % 4) >= 2) ? 4'hC : 4'h3;
    endfunction

    function automatic logic [31:0] model_wdata(input int sz, input bit st, input logic [31:0] wd);
        if (!st) return 32'h0;
        if (sz == 1) return (wd % 256) * 32'h0101_0101;
        if (sz == 2) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    // k = BUSY cycle on which ack arrives (1-based); 0 = never.
    task automatic run_txn(input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input int k, input logic [31:0] rdata);
        int sz, n_stall;
        bit st, ld, mis, go, acked;
        sz  = size_of(op);
        st  = is_st(op);
        ld  = (sz != 0) && !st;
        mis = (sz != 0) && ((addr % sz) != 0);
        go  = (sz != 0) && !mis;
        acked   = 1'b0;
        n_stall = 0;

        Instr_M = {op, 26'($urandom)};
        ALUout  = addr;
        WD_M    = wd;
        #1;
        check_eq("stall_idle", 32'(stall), 32'(go));
        check_eq("adel", 32'(adel), 32'(ld && mis));
        check_eq("ades", 32'(ades), 32'(st && mis));
        if (!go) begin
            step;
            check_eq("req_noissue", 32'(bus.mem_req), 32'd0);
            check_eq("dout_noissue", DMout1, exp_dout);
            return;
        end
        n_stall = 1;
        step;
        check_eq("req_issue", 32'(bus.mem_req), 32'd1);
        check_eq("we", 32'(bus.mem_we), 32'(st));
        check_eq("addr", bus.mem_addr, addr - (addr % 4));
        check_eq("be", 32'(bus.mem_be), 32'(model_be(sz, st, addr)));
        check_eq("wdata", bus.mem_wdata, model_wdata(sz, st, wd));
        for (int i = 1; i <= TIMEOUT; i++) begin
            check_eq("stall_busy", 32'(stall), 32'd1);
            n_stall++;
            if (i == k) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdata;
                step;
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
                if (ld) exp_dout = rdata;
                acked = 1'b1;
                break;
            end
            step;
            if (i == TIMEOUT) begin
                if (ld) exp_dout = 32'h0;
                break;
            end
            check_eq("req_held", 32'(bus.mem_req), 32'd1);
        end
        check_eq("stall_done", 32'(stall), 32'd0);
        check_eq("req_done", 32'(bus.mem_req), 32'd0);
        check_eq("bus_err", 32'(bus_err), 32'(!acked));
        check_eq("dout_done", DMout1, exp_dout);
        check_eq("stall_cycles", 32'(n_stall), acked ? 32'(k + 1) : 32'(TIMEOUT + 1));
        if ($urandom_range(0, 1) == 1) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = $urandom;
        end
        step;
        bus.mem_ack = 1'b0;
        check_eq("bus_err_idle", 32'(bus_err), 32'd0);
        check_eq("dout_idle", DMout1, exp_dout);
        check_eq("req_idle", 32'(bus.mem_req), 32'd0);
    endtask

    logic [5:0] ops [0:10] = '{6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011,
                               6'b101000, 6'b101001, 6'b101011, 6'b000000, 6'b001001, 6'b001111};

    initial begin
        int r, k;
        reset         = 1'b1;
        Instr_M       = 32'h0;
        ALUout        = 32'h0;
        WD_M          = 32'h0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        exp_dout      = 32'h0;
        step;
        step;
        check_eq("rst_req", 32'(bus.mem_req), 32'd0);
        check_eq("rst_dout", DMout1, 32'h0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_bus_err", 32'(bus_err), 32'd0);
        reset = 1'b0;

        run_txn(6'b100011, 32'h0000_0104, 32'h0, 1, 32'hDEAD_BEEF);
        run_txn(6'b101000, 32'h0000_0203, 32'h1234_5678, 3, 32'h0);
        run_txn(6'b101001, 32'h0000_0202, 32'h1234_5678, 2, 32'h0);
        run_txn(6'b100001, 32'h0000_0201, 32'h0, 1, 32'h0);
        run_txn(6'b101011, 32'h0000_0102, 32'h0, 1, 32'h0);
        run_txn(6'b100011, 32'h0000_0300, 32'h0, 0, 32'h0);
        run_txn(6'b100011, 32'h0000_0400, 32'h0, TIMEOUT, 32'hCAFE_F00D);

        // Reset on the 2nd BUSY cycle, then a late ack that must be ignored.
        Instr_M = {6'b100011, 26'h0};
        ALUout  = 32'h0000_0040;
        step;
        step;
        reset = 1'b1;
        step;
        reset   = 1'b0;
        Instr_M = 32'h0000_0021;
        exp_dout = 32'h0;
        #1;
        check_eq("mid_rst_req", 32'(bus.mem_req), 32'd0);
        check_eq("mid_rst_we", 32'(bus.mem_we), 32'd0);
        check_eq("mid_rst_addr", bus.mem_addr, 32'h0);
        check_eq("mid_rst_be", 32'(bus.mem_be), 32'd0);
        check_eq("mid_rst_wdata", bus.mem_wdata, 32'h0);
        check_eq("mid_rst_dout", DMout1, 32'h0);
        check_eq("mid_rst_stall", 32'(stall), 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        step;
        bus.mem_ack = 1'b0;
        check_eq("late_ack_dout", DMout1, 32'h0);
        check_eq("late_ack_req", 32'(bus.mem_req), 32'd0);
        check_eq("late_ack_stall", 32'(stall), 32'd0);
        check_eq("late_ack_err", 32'(bus_err), 32'd0);

        run_txn(6'b100011, 32'h0000_0010, 32'h0, 1, 32'h0BAD_F00D);
        run_txn(6'b101011, 32'h0000_0014, 32'hA5A5_5A5A, 1, 32'h0);
        run_txn(6'b000000, 32'h0000_0018, 32'h0, 1, 32'h0);

        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      k = 0;
            else if (r < 3)  k = $urandom_range(1, TIMEOUT);
            else             k = $urandom_range(1, 4);
            run_txn(ops[$urandom_range(0, 10)], $urandom, $urandom, k, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
